// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Data-memory load/store stage. Aligns and lane-replicates
//               stores, extracts and extends loads, and drives the dmem
//               valid/ready port. Optional macro LSU_TIMEOUT_EN adds a bus
//               timeout that retires a stalled access with bus_err_o.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int WORD_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WORD_WIDTH-1:0] wdata_i,
    input  logic [4:0]            rd_addr_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [WORD_WIDTH-1:0] rdata_o,
    output logic [4:0]            rd_addr_o,
    output logic                  rf_we_o,
    output logic                  misaligned_o,
    output logic                  bus_err_o,
    output logic                  dmem_valid_o,
    input  logic                  dmem_ready_i,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [WORD_WIDTH-1:0] dmem_wdata_o,
    output logic [3:0]            dmem_we_o,
    input  logic [WORD_WIDTH-1:0] dmem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    we_q, we_d;
    logic [1:0]              size_q, size_d;
    logic                    uns_q, uns_d;
    logic [1:0]              off_q, off_d;
    logic [4:0]              rd_q, rd_d;
    logic [ADDR_WIDTH-1:0]   maddr_q, maddr_d;
    logic [WORD_WIDTH-1:0]   mwdata_q, mwdata_d;
    logic [3:0]              mbe_q, mbe_d;
    logic [WORD_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    mis_q, mis_d;
    logic                    berr_q, berr_d;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

    logic                    w_misaligned;
    logic [3:0]              w_be;
    logic [WORD_WIDTH-1:0]   w_wdata;
    logic [WORD_WIDTH-1:0]   w_shifted;
    logic [WORD_WIDTH-1:0]   w_load;

    always_comb begin
        w_misaligned = 1'b0;
        w_be         = 4'b1111;
        w_wdata      = wdata_i;
        case (size_i)
            2'b00: begin
                w_be    = 4'b0001 << addr_i[1:0];
                w_wdata = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                w_misaligned = addr_i[0];
                w_be         = 4'b0011 << addr_i[1:0];
                w_wdata      = {2{wdata_i[15:0]}};
            end
            2'b10:   w_misaligned = (addr_i[1:0] != 2'b00);
            default: w_misaligned = 1'b1;
        endcase
    end

    // Loaded lane is moved to bit 0 first, then truncated and extended.
    assign w_shifted = dmem_rdata_i >> {off_q, 3'b000};

    always_comb begin
        w_load = w_shifted;
        case (size_q)
            2'b00:   w_load = {{(WORD_WIDTH-8){w_shifted[7] & ~uns_q}}, w_shifted[7:0]};
            2'b01:   w_load = {{(WORD_WIDTH-16){w_shifted[15] & ~uns_q}}, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        uns_d    = uns_q;
        off_d    = off_q;
        rd_d     = rd_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        mbe_d    = mbe_q;
        rdata_d  = rdata_q;
        mis_d    = mis_q;
        berr_d   = berr_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    we_d     = we_i;
                    size_d   = size_i;
                    uns_d    = unsigned_i;
                    off_d    = addr_i[1:0];
                    rd_d     = rd_addr_i;
                    maddr_d  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
                    mwdata_d = we_i ? w_wdata : '0;
                    mbe_d    = we_i ? w_be : 4'b0000;
                    berr_d   = 1'b0;
                    mis_d    = w_misaligned;
                    if (w_misaligned) begin
                        rdata_d = '0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACCESS;
`ifdef LSU_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            S_ACCESS: begin
                if (dmem_ready_i) begin
                    rdata_d = we_q ? '0 : w_load;
                    state_d = S_DONE;
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    rdata_d = '0;
                    berr_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            off_q    <= 2'b00;
            rd_q     <= 5'd0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            mbe_q    <= 4'b0000;
            rdata_q  <= '0;
            mis_q    <= 1'b0;
            berr_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            off_q    <= off_d;
            rd_q     <= rd_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            mbe_q    <= mbe_d;
            rdata_q  <= rdata_d;
            mis_q    <= mis_d;
            berr_q   <= berr_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign ready_o      = (state_q == S_IDLE) & ~rst;
    assign dmem_valid_o = (state_q == S_ACCESS);
    assign dmem_addr_o  = maddr_q;
    assign dmem_wdata_o = mwdata_q;
    assign dmem_we_o    = dmem_valid_o ? mbe_q : 4'b0000;
    assign done_o       = (state_q == S_DONE);
    assign rdata_o      = rdata_q;
    assign rd_addr_o    = rd_q;
    assign misaligned_o = done_o & mis_q;
    assign rf_we_o      = done_o & ~we_q & ~mis_q & ~berr_q & (rd_q != 5'd0);
`ifdef LSU_TIMEOUT_EN
    assign bus_err_o    = done_o & berr_q;
`else
    assign bus_err_o    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit with a byte-level
//               reference model and randomized transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

`ifdef LSU_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 16;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_i = 1'b0, we_i = 1'b0, unsigned_i = 1'b0;
    logic [1:0]  size_i = 2'b00;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        ready_o, done_o, rf_we_o, misaligned_o, bus_err_o, dmem_valid_o;
    logic [31:0] rdata_o, dmem_addr_o, dmem_wdata_o;
    logic [4:0]  rd_addr_o;
    logic [3:0]  dmem_we_o;
    logic        dmem_ready_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;

    int n_chk = 0;
    int n_pass = 0;

    load_store_unit #(.ADDR_WIDTH(32), .WORD_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .size_i(size_i),
        .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .rd_addr_i(rd_addr_i), .ready_o(ready_o), .done_o(done_o),
        .rdata_o(rdata_o), .rd_addr_o(rd_addr_o), .rf_we_o(rf_we_o),
        .misaligned_o(misaligned_o), .bus_err_o(bus_err_o),
        .dmem_valid_o(dmem_valid_o), .dmem_ready_i(dmem_ready_i),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_we_o(dmem_we_o), .dmem_rdata_i(dmem_rdata_i)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] a);
        int off = int'(a % 4);
        return (sz == 2'd3) || (sz == 2'd1 && (off % 2) == 1) || (sz == 2'd2 && off != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic we, input logic [1:0] sz, input logic [31:0] a);
        int nbytes = 1 << sz;
        int off = int'(a % 4);
        if (!we) return 4'd0;
        return 4'(((1 << nbytes) - 1) << off);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return {24'd0, wd[7:0]} * 32'h01010101;
        if (sz == 2'd1) return {16'd0, wd[15:0]} * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                           input logic [31:0] a, input logic [31:0] mem);
        longint nbits = 64'd8 << sz;
        longint v = longint'(mem) >> (8 * (a % 4));
        if (nbits < 32) begin
            v = v % (64'd1 << nbits);
            if (!uns && v >= (64'd1 << (nbits - 1))) v = v - (64'd1 << nbits);
        end
        return v[31:0];
    endfunction

    // Drives one request and records what the DUT did; no checking here.
    task automatic run_txn(
        input  logic we, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
        input  logic [31:0] wd, input logic [4:0] rd, input int waits, input logic [31:0] mem,
        output int vcyc, output int lat, output logic [31:0] o_addr, output logic [31:0] o_wdata,
        output logic [3:0] o_we, output logic o_stable, output logic o_busy_ok,
        output logic [31:0] o_rdata, output logic [4:0] o_rd, output logic o_rfwe,
        output logic o_mis, output logic o_berr, output logic o_next_done, output logic o_next_ready);
        logic fin;
        vcyc = 0; lat = -1; o_addr = '0; o_wdata = '0; o_we = '0; o_stable = 1'b1;
        o_busy_ok = 1'b1; o_rdata = '0; o_rd = '0; o_rfwe = 1'b0; o_mis = 1'b0; o_berr = 1'b0;
        o_next_done = 1'b0; o_next_ready = 1'b0; fin = 1'b0;
        @(negedge clk);
        we_i = we; size_i = sz; unsigned_i = uns; addr_i = addr; wdata_i = wd; rd_addr_i = rd;
        req_i = 1'b1;
        @(negedge clk);
        req_i = 1'b0;
        for (int c = 0; c < 64 && !fin; c++) begin
            if (done_o) begin
                lat = c + 1; o_rdata = rdata_o; o_rd = rd_addr_o; o_rfwe = rf_we_o;
                o_mis = misaligned_o; o_berr = bus_err_o; fin = 1'b1;
            end else begin
                if (ready_o) o_busy_ok = 1'b0;
                if (dmem_valid_o) begin
                    if (vcyc == 0) begin
                        o_addr = dmem_addr_o; o_wdata = dmem_wdata_o; o_we = dmem_we_o;
                    end else if (o_addr !== dmem_addr_o || o_wdata !== dmem_wdata_o || o_we !== dmem_we_o) begin
                        o_stable = 1'b0;
                    end
                    vcyc++;
                    dmem_ready_i = (vcyc > waits);
                    dmem_rdata_i = mem;
                end else begin
                    dmem_ready_i = 1'b0;
                end
                @(negedge clk);
            end
        end
        dmem_ready_i = 1'b0;
        dmem_rdata_i = $urandom;
        @(negedge clk);
        o_next_done = done_o;
        o_next_ready = ready_o;
    endtask

    int vc, lt;
    logic [31:0] oa, ow, ord;
    logic [3:0] owe;
    logic ost, obusy, orf, omis, oberr, ond, onr;
    logic [4:0] ordd;

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            rst = 1'b1; req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; addr_i = 32'h100; rd_addr_i = 5'd5;
            @(negedge clk);
            n_chk++;
            if ({ready_o, done_o, dmem_valid_o, rf_we_o, misaligned_o, bus_err_o, dmem_we_o, rd_addr_o} !== 13'd0
                || rdata_o !== 32'd0 || dmem_addr_o !== 32'd0 || dmem_wdata_o !== 32'd0)
                $display("FAIL reset_outputs: got rdy=%b done=%b val=%b addr=%h want all 0",
                         ready_o, done_o, dmem_valid_o, dmem_addr_o);
            else n_pass++;
        end
        rst = 1'b0; req_i = 1'b0;
        #1;
        n_chk++;
        if (ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready_o); else n_pass++;
        @(negedge clk);
        n_chk++;
        if (dmem_valid_o !== 1'b0) $display("FAIL reset_novalid: got %b want 0", dmem_valid_o); else n_pass++;
    endtask

    task automatic test_load_word();
        run_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd5, 2, 32'hDEADBEEF,
                vc, lt, oa, ow, owe, ost, obusy, ord, ordd, orf, omis, oberr, ond, onr);
        n_chk++; if (vc !== 3) $display("FAIL lw_valid_cycles: got %0d want 3", vc); else n_pass++;
        n_chk++; if (oa !== 32'h100 || owe !== 4'b0000) $display("FAIL lw_addr_we: got %h/%b want 00000100/0000", oa, owe); else n_pass++;
        n_chk++; if (lt !== 4) $display("FAIL lw_latency: got %0d want 4", lt); else n_pass++;
        n_chk++; if (ord !== 32'hDEADBEEF || ordd !== 5'd5 || orf !== 1'b1)
            $display("FAIL lw_result: got %h rd=%0d rfwe=%b want deadbeef rd=5 rfwe=1", ord, ordd, orf); else n_pass++;
        n_chk++; if (!ost || !obusy || ond !== 1'b0 || onr !== 1'b1)
            $display("FAIL lw_protocol: got stable=%b busy_ok=%b next_done=%b next_ready=%b want 1 1 0 1", ost, obusy, ond, onr); else n_pass++;
        run_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd0, 2, 32'hDEADBEEF,
                vc, lt, oa, ow, owe, ost, obusy, ord, ordd, orf, omis, oberr, ond, onr);
        n_chk++; if (orf !== 1'b0 || ord !== 32'hDEADBEEF) $display("FAIL lw_rd0: got rfwe=%b data=%h want 0 deadbeef", orf, ord); else n_pass++;
    endtask

    task automatic test_load_subword();
        run_txn(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 5'd7, 0, 32'h80FF1234,
                vc, lt, oa, ow, owe, ost, obusy, ord, ordd, orf, omis, oberr, ond, onr);
        n_chk++; if (ord !== 32'hFFFFFF80 || oa !== 32'h100) $display("FAIL lb: got %h addr %h want ffffff80 00000100", ord, oa); else n_pass++;
        run_txn(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 5'd7, 1, 32'h80FF1234,
                vc, lt, oa, ow, owe, ost, obusy, ord, ordd, orf, omis, oberr, ond, onr);
        n_chk++; if (ord !== 32'h00000080) $display("FAIL lbu: got %h want 00000080", ord); else n_pass++;
        run_txn(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 5'd7, 0, 32'h80FF1234,
                vc, lt, oa, ow, owe, ost, obusy, ord, ordd, orf, omis, oberr, ond, onr);
        n_chk++; if (ord !== 32'hFFFF80FF) $display("FAIL lh: got %h want ffff80ff", ord); else n_pass++;
    endtask

    task automatic test_store();
        run_txn(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, 5'd9, 1, 32'h12345678,
                vc, lt, oa, ow, owe, ost, obusy, ord, ordd, orf, omis, oberr, ond, onr);
        n_chk++; if (oa !== 32'h200 || owe !== 4'b1100 || ow !== 32'hABCDABCD)
            $display("FAIL sh_bus: got %h/%b/%h want 00000200/1100/abcdabcd", oa, owe, ow); else n_pass++;
        n_chk++; if (orf !== 1'b0 || ord !== 32'd0 || lt !== 3)
            $display("FAIL sh_done: got rfwe=%b data=%h lat=%0d want 0 0 3", orf, ord, lt); else n_pass++;
    endtask

    task automatic test_misaligned();
        run_txn(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 5'd3, 0, 32'h11111111,
                vc, lt, oa, ow, owe, ost, obusy, ord, ordd, orf, omis, oberr, ond, onr);
        n_chk++; if (vc !== 0 || lt !== 1 || omis !== 1'b1 || orf !== 1'b0 || onr !== 1'b1)
            $display("FAIL lw_misaligned: got vcyc=%0d lat=%0d mis=%b rfwe=%b ready=%b want 0 1 1 0 1", vc, lt, omis, orf, onr); else n_pass++;
        run_txn(1'b1, 2'd3, 1'b0, 32'h100, 32'h5, 5'd3, 0, 32'h11111111,
                vc, lt, oa, ow, owe, ost, obusy, ord, ordd, orf, omis, oberr, ond, onr);
        n_chk++; if (vc !== 0 || lt !== 1 || omis !== 1'b1 || orf !== 1'b0 || onr !== 1'b1)
            $display("FAIL size11: got vcyc=%0d lat=%0d mis=%b rfwe=%b ready=%b want 0 1 1 0 1", vc, lt, omis, orf, onr); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic we, uns, mis;
            logic [1:0] sz;
            logic [31:0] a, wd, mem;
            logic [4:0] rd;
            int w;
            we = 1'($urandom); uns = 1'($urandom); sz = 2'($urandom);
            a = $urandom; wd = $urandom; mem = $urandom; rd = 5'($urandom);
            w = int'($urandom_range(0, 3));
            mis = m_mis(sz, a);
            run_txn(we, sz, uns, a, wd, rd, w, mem,
                    vc, lt, oa, ow, owe, ost, obusy, ord, ordd, orf, omis, oberr, ond, onr);
            n_chk++;
            if (omis !== mis || vc !== (mis ? 0 : w + 1) || lt !== (mis ? 1 : w + 2) || !obusy || !ost || onr !== 1'b1)
                $display("FAIL rnd%0d_flow: got mis=%b vcyc=%0d lat=%0d want mis=%b vcyc=%0d lat=%0d", i, omis, vc, lt, mis, mis ? 0 : w + 1, mis ? 1 : w + 2);
            else n_pass++;
            n_chk++;
            if (orf !== (!we && !mis && rd != 0) || ordd !== rd)
                $display("FAIL rnd%0d_rf: got rfwe=%b rd=%0d want rfwe=%b rd=%0d", i, orf, ordd, !we && !mis && rd != 0, rd);
            else n_pass++;
            if (!mis) begin
                n_chk++;
                if (oa !== {a[31:2], 2'b00} || owe !== m_be(we, sz, a) || (we && ow !== m_wdata(sz, wd)))
                    $display("FAIL rnd%0d_bus: got %h/%b/%h want %h/%b/%h", i, oa, owe, ow, {a[31:2], 2'b00}, m_be(we, sz, a), m_wdata(sz, wd));
                else n_pass++;
                n_chk++;
                if (ord !== (we ? 32'd0 : m_load(sz, uns, a, mem)))
                    $display("FAIL rnd%0d_rdata: got %h want %h", i, ord, we ? 32'd0 : m_load(sz, uns, a, mem));
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_access();
        logic saw_done = 1'b0;
        @(negedge clk);
        we_i = 1'b0; size_i = 2'd2; addr_i = 32'h300; rd_addr_i = 5'd4; req_i = 1'b1;
        @(negedge clk);
        req_i = 1'b0;
        n_chk++; if (dmem_valid_o !== 1'b1) $display("FAIL midrst_access: got %b want 1", dmem_valid_o); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_chk++; if (dmem_valid_o !== 1'b0 || done_o !== 1'b0) $display("FAIL midrst_drop: got valid=%b done=%b want 0 0", dmem_valid_o, done_o); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            if (done_o || dmem_valid_o) saw_done = 1'b1;
            @(negedge clk);
        end
        n_chk++; if (saw_done !== 1'b0 || ready_o !== 1'b1) $display("FAIL midrst_idle: got activity=%b ready=%b want 0 1", saw_done, ready_o); else n_pass++;
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        run_txn(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 5'd6, 1000, 32'h0,
                vc, lt, oa, ow, owe, ost, obusy, ord, ordd, orf, omis, oberr, ond, onr);
        n_chk++; if (vc !== TO + 1 || oberr !== 1'b1 || orf !== 1'b0 || lt !== TO + 2)
            $display("FAIL timeout: got vcyc=%0d berr=%b rfwe=%b lat=%0d want %0d 1 0 %0d", vc, oberr, orf, lt, TO + 1, TO + 2); else n_pass++;
        run_txn(1'b0, 2'd2, 1'b0, 32'h404, 32'h0, 5'd6, TO, 32'hCAFEF00D,
                vc, lt, oa, ow, owe, ost, obusy, ord, ordd, orf, omis, oberr, ond, onr);
        n_chk++; if (oberr !== 1'b0 || ord !== 32'hCAFEF00D || orf !== 1'b1 || vc !== TO + 1)
            $display("FAIL timeout_ready_wins: got berr=%b data=%h rfwe=%b vcyc=%0d want 0 cafef00d 1 %0d", oberr, ord, orf, vc, TO + 1); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_load_word();
        test_load_subword();
        test_store();
        test_misaligned();
        test_random();
        test_reset_mid_access();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
